dsp_mult_pipe: RTL
==================

// Module: dsp_mult_pipe
//
// PURPOSE
// Elastic, back-pressurable successor to the shared-unit dot-product multiplier
// wrapper. Wraps dsp_mult with a configurable number of operand (pre) and result
// (post) pipeline stages, each with its own valid bit, and honours Ack_i so
// results are held until the shared-APU interconnect consumes them.
// Adds flush and a busy status.
//
// PARAMETERS
// NUM_PRE_REGS   1        operand stages in front of dsp_mult (>=0)
// NUM_POST_REGS  1        result stages behind dsp_mult (>=0)
// TAG_WIDTH      WAPUTAG  width of tag travelling with each operation
//
// PORTS
// clk_i     in   1             clock
// rst_ni    in   1             reset; synchronous, active-low
// En_i      in   1             request valid
// Op_i      in   DSP_OP_WIDTH  dsp_mult operator
// OpA_i     in   DSP_WIDTH     operand A
// OpB_i     in   DSP_WIDTH     operand B
// OpC_i     in   DSP_WIDTH     operand C (accumulator)
// Tag_i     in   TAG_WIDTH     request tag
// Flag_i    in   2             dot_signed flags
// Flush_i   in   1             drop all in-flight operations
// Ready_o   out  1             request accepted this cycle when En_i && Ready_o
// Res_o     out  DSP_WIDTH     result
// Tag_o     out  TAG_WIDTH     tag of the result
// Valid_o   out  1             result valid
// Status_o  out  2             [0] busy (any stage valid); [1] tied 0
// Ack_i     in   1             result consumed when Valid_o && Ack_i
//
// BEHAVIOUR
// - L = NUM_PRE_REGS+NUM_POST_REGS. Stages are numbered 1..L. Stage k holds
//   valid v[k] plus payload: Op/Flag/A/B/C/Tag for pre stages, Res/Tag for post.
// - Reset, at posedge with rst_ni=0: every v[k]=0 and every payload reg=0.
//   Hence Valid_o=0, Res_o=0, Tag_o=0, Status_o=0, and Ready_o=1.
// - Operand isolation: operands, Op and Flag are forced to 0 when En_i=0.
//   dsp_mult therefore sees zeros on idle cycles.
// - Advance rule: stage L moves on when v[L]=0 or Ack_i=1. Stage k<L moves on
//   when v[k]=0 or stage k+1 moves on.
//   Ready_o = stage-1 move condition. The path Ack_i->Ready_o is combinational
//   through the chain.
// - When stage k moves on: v[k] <= v[k-1], where v[0] = En_i && Ready_o.
//   The payload loads only if v[k-1]=1. Otherwise the payload holds (no
//   toggling on bubbles).
// - A stalled stage holds valid and payload unchanged. Valid_o/Res_o/Tag_o stay
//   stable from the first Valid_o=1 cycle until the Ack cycle.
// - Bubbles collapse: a non-empty stage whose successor is empty advances even
//   while the output stalls.
// - Latency with no stall is L cycles from accept to Valid_o. Throughput is one
//   op per cycle while Ack_i=1.
// - dsp_mult is combinational between the last pre stage and the first post
//   stage. If NUM_PRE_REGS=0 it takes the isolated inputs. If NUM_POST_REGS=0
//   Res_o is the dsp_mult output of stage L.
// - L=0: fully combinational. Valid_o=En_i, Ready_o=Ack_i, Tag_o=Tag_i,
//   busy=0.
// - Flush_i=1 at a posedge: all v[k] <= 0 and a request in the same cycle is
//   not captured. Ready_o is still driven by the advance rule, but acceptance
//   is suppressed. Payload regs may keep stale values.
//   Priority: reset > flush > advance.
// - Simultaneous accept and output Ack at full occupancy: the whole pipe
//   shifts and stays full, with no lost or duplicated op.
// - En_i=1 with Ready_o=0: nothing is captured. The requester holds inputs.
// - Status_o[0] = OR of all v[k].
//
// TESTING
// 1 Reset, PRE=1 POST=1: hold rst_ni=0 for 2 clk. Then Valid_o=0, Res_o=0,
//   Tag_o=0, Status_o=0, Ready_o=1.
// 2 Single op, A=3 B=5 C=2, tag=0x5, Ack_i=1 tied. Valid_o=1 exactly 2 cycles
//   later with tag 0x5. Res_o equals the dsp_mult model for these inputs.
// 3 Back-to-back tags 1..8 with Ack_i=1. Tags appear 1..8 on consecutive
//   cycles, Ready_o is constantly 1, 8 results in 8 cycles.
// 4 Stall: Ack_i=0 while issuing tags 1,2,3. Ready_o drops after 2 accepts
//   (L=2). Tag_o=1 stays stable.
//   Then Ack_i=1 for 3 cycles: tags 1,2,3 in order. Tag 3 is accepted on the
//   first Ack cycle.
// 5 Flush with the pipe full (tags 4,5) and En_i=1 tag 6 in the same cycle.
//   Next cycle Valid_o=0 and Status_o[0]=0. Tags 4, 5, 6 never appear.
// 6 L=0 and PRE=3 POST=0 builds: L=0 gives Valid_o=En_i and Ready_o=Ack_i
//   combinationally. PRE=3 POST=0 gives latency 3 and sequence 1..8 preserved
//   under random Ack_i.

Source files
------------

// File: rtl/dsp_mult_pipe_if.sv
// Request/result bundle between a shared-APU requester and dsp_mult_pipe.
// Handshake: a request transfers on a clock edge where En_i && Ready_o, and a
// result transfers on a clock edge where Valid_o && Ack_i. Once Valid_o is
// raised, Valid_o/Res_o/Tag_o hold steady until the transfer edge. Flush_i
// empties the pipe and blocks any request offered in the same cycle.
interface dsp_mult_pipe_if #(
    parameter int DSP_WIDTH    = 32,
    parameter int DSP_OP_WIDTH = 3,
    parameter int TAG_WIDTH    = 4
);
    logic                    En_i;
    logic [DSP_OP_WIDTH-1:0] Op_i;
    logic [DSP_WIDTH-1:0]    OpA_i;
    logic [DSP_WIDTH-1:0]    OpB_i;
    logic [DSP_WIDTH-1:0]    OpC_i;
    logic [TAG_WIDTH-1:0]    Tag_i;
    logic [1:0]              Flag_i;
    logic                    Flush_i;
    logic                    Ready_o;
    logic [DSP_WIDTH-1:0]    Res_o;
    logic [TAG_WIDTH-1:0]    Tag_o;
    logic                    Valid_o;
    logic [1:0]              Status_o;
    logic                    Ack_i;

    modport master (
        output En_i, Op_i, OpA_i, OpB_i, OpC_i, Tag_i, Flag_i, Flush_i, Ack_i,
        input  Ready_o, Res_o, Tag_o, Valid_o, Status_o
    );

    modport slave (
        input  En_i, Op_i, OpA_i, OpB_i, OpC_i, Tag_i, Flag_i, Flush_i, Ack_i,
        output Ready_o, Res_o, Tag_o, Valid_o, Status_o
    );
endinterface

// File: rtl/dsp_mult_pipe.sv
// Elastic multiplier pipeline: operand stages, the combinational dsp_mult
// datapath, then result stages. Every stage carries its own valid bit and
// stalls only when its successor cannot take data, so bubbles collapse.

// Combinational multiply / multiply-accumulate / packed dot-product unit.
// Flag_i[0] marks lanes of A as signed, Flag_i[1] marks lanes of B as signed.
module dsp_mult #(
    parameter int DSP_WIDTH    = 32,
    parameter int DSP_OP_WIDTH = 3
) (
    input  logic [DSP_OP_WIDTH-1:0] op_i,
    input  logic [1:0]              flag_i,
    input  logic [DSP_WIDTH-1:0]    a_i,
    input  logic [DSP_WIDTH-1:0]    b_i,
    input  logic [DSP_WIDTH-1:0]    c_i,
    output logic [DSP_WIDTH-1:0]    res_o
);
    localparam logic [DSP_OP_WIDTH-1:0] OP_MUL   = DSP_OP_WIDTH'(0);
    localparam logic [DSP_OP_WIDTH-1:0] OP_MAC   = DSP_OP_WIDTH'(1);
    localparam logic [DSP_OP_WIDTH-1:0] OP_DOT16 = DSP_OP_WIDTH'(2);
    localparam logic [DSP_OP_WIDTH-1:0] OP_DOT8  = DSP_OP_WIDTH'(3);
    localparam int HW = DSP_WIDTH / 2;
    localparam int QW = DSP_WIDTH / 4;

    logic [DSP_WIDTH-1:0] ea;
    logic [DSP_WIDTH-1:0] eb;
    logic [DSP_WIDTH-1:0] acc;

    // Select the operation; dot products sign/zero-extend each lane before summing.
    always_comb begin
        res_o = '0;
        acc   = '0;
        ea    = '0;
        eb    = '0;
        case (op_i)
            OP_MUL: res_o = a_i * b_i;
            OP_MAC: res_o = a_i * b_i + c_i;
            OP_DOT16: begin
                acc = c_i;
                for (int i = 0; i < 2; i++) begin
                    ea  = {{(DSP_WIDTH-HW){flag_i[0] & a_i[i*HW+HW-1]}}, a_i[i*HW +: HW]};
                    eb  = {{(DSP_WIDTH-HW){flag_i[1] & b_i[i*HW+HW-1]}}, b_i[i*HW +: HW]};
                    acc = acc + ea * eb;
                end
                res_o = acc;
            end
            OP_DOT8: begin
                acc = c_i;
                for (int i = 0; i < 4; i++) begin
                    ea  = {{(DSP_WIDTH-QW){flag_i[0] & a_i[i*QW+QW-1]}}, a_i[i*QW +: QW]};
                    eb  = {{(DSP_WIDTH-QW){flag_i[1] & b_i[i*QW+QW-1]}}, b_i[i*QW +: QW]};
                    acc = acc + ea * eb;
                end
                res_o = acc;
            end
            default: res_o = '0;
        endcase
    end
endmodule

module dsp_mult_pipe #(
    parameter int NUM_PRE_REGS  = 1,
    parameter int NUM_POST_REGS = 1,
    parameter int TAG_WIDTH     = 4,
    parameter int DSP_WIDTH     = 32,
    parameter int DSP_OP_WIDTH  = 3
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    dsp_mult_pipe_if.slave bus
);
    localparam int L = NUM_PRE_REGS + NUM_POST_REGS;

    logic [DSP_OP_WIDTH-1:0] iso_op;
    logic [1:0]              iso_flag;
    logic [DSP_WIDTH-1:0]    iso_a;
    logic [DSP_WIDTH-1:0]    iso_b;
    logic [DSP_WIDTH-1:0]    iso_c;

    // Operands seen by the multiplier path, and the tag travelling with them.
    logic [DSP_OP_WIDTH-1:0] m_op;
    logic [1:0]              m_flag;
    logic [DSP_WIDTH-1:0]    m_a;
    logic [DSP_WIDTH-1:0]    m_b;
    logic [DSP_WIDTH-1:0]    m_c;
    logic [TAG_WIDTH-1:0]    m_tag;
    logic [DSP_WIDTH-1:0]    m_res;

    // Zero the operands on idle cycles so the datapath does not toggle.
    always_comb begin
        iso_op   = bus.En_i ? bus.Op_i   : '0;
        iso_flag = bus.En_i ? bus.Flag_i : '0;
        iso_a    = bus.En_i ? bus.OpA_i  : '0;
        iso_b    = bus.En_i ? bus.OpB_i  : '0;
        iso_c    = bus.En_i ? bus.OpC_i  : '0;
    end

    dsp_mult #(
        .DSP_WIDTH    (DSP_WIDTH),
        .DSP_OP_WIDTH (DSP_OP_WIDTH)
    ) u_mult (
        .op_i   (m_op),
        .flag_i (m_flag),
        .a_i    (m_a),
        .b_i    (m_b),
        .c_i    (m_c),
        .res_o  (m_res)
    );

    generate
        if (L == 0) begin : g_comb
            assign m_op         = iso_op;
            assign m_flag       = iso_flag;
            assign m_a          = iso_a;
            assign m_b          = iso_b;
            assign m_c          = iso_c;
            assign m_tag        = bus.Tag_i;
            assign bus.Ready_o  = bus.Ack_i;
            assign bus.Valid_o  = bus.En_i;
            assign bus.Res_o    = m_res;
            assign bus.Tag_o    = m_tag;
            assign bus.Status_o = 2'b00;
        end else begin : g_pipe
            logic [L:1] v_q;
            logic [L:1] v_in;
            logic [L:1] mv;
            logic       accept;

            // Move chain: the last stage moves when empty or acked, each earlier
            // stage when empty or when its successor moves.
            always_comb begin
                mv    = '0;
                mv[L] = !v_q[L] || bus.Ack_i;
                for (int k = L - 1; k >= 1; k--) begin
                    mv[k] = !v_q[k] || mv[k+1];
                end
            end

            assign accept = bus.En_i && mv[1] && !bus.Flush_i;

            // Valid bit offered to each stage by its predecessor.
            always_comb begin
                v_in    = '0;
                v_in[1] = accept;
                for (int k = 2; k <= L; k++) begin
                    v_in[k] = v_q[k-1];
                end
            end

            // Stage valid bits: reset, then flush, then normal advance.
            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    v_q <= '0;
                end else if (bus.Flush_i) begin
                    v_q <= '0;
                end else begin
                    for (int k = 1; k <= L; k++) begin
                        if (mv[k]) v_q[k] <= v_in[k];
                    end
                end
            end

            assign bus.Ready_o  = mv[1];
            assign bus.Valid_o  = v_q[L];
            assign bus.Status_o = {1'b0, |v_q};

            if (NUM_PRE_REGS > 0) begin : g_pre
                localparam int NP = NUM_PRE_REGS;
                logic [DSP_OP_WIDTH-1:0] op_q   [1:NP];
                logic [DSP_OP_WIDTH-1:0] op_in  [1:NP];
                logic [1:0]              flg_q  [1:NP];
                logic [1:0]              flg_in [1:NP];
                logic [DSP_WIDTH-1:0]    a_q    [1:NP];
                logic [DSP_WIDTH-1:0]    a_in   [1:NP];
                logic [DSP_WIDTH-1:0]    b_q    [1:NP];
                logic [DSP_WIDTH-1:0]    b_in   [1:NP];
                logic [DSP_WIDTH-1:0]    c_q    [1:NP];
                logic [DSP_WIDTH-1:0]    c_in   [1:NP];
                logic [TAG_WIDTH-1:0]    t_q    [1:NP];
                logic [TAG_WIDTH-1:0]    t_in   [1:NP];

                // Operand payload offered to each pre stage.
                always_comb begin
                    op_in[1]  = iso_op;
                    flg_in[1] = iso_flag;
                    a_in[1]   = iso_a;
                    b_in[1]   = iso_b;
                    c_in[1]   = iso_c;
                    t_in[1]   = bus.Tag_i;
                    for (int j = 2; j <= NP; j++) begin
                        op_in[j]  = op_q[j-1];
                        flg_in[j] = flg_q[j-1];
                        a_in[j]   = a_q[j-1];
                        b_in[j]   = b_q[j-1];
                        c_in[j]   = c_q[j-1];
                        t_in[j]   = t_q[j-1];
                    end
                end

                // Operand registers load only when a valid op moves in.
                always_ff @(posedge clk_i) begin
                    if (!rst_ni) begin
                        for (int j = 1; j <= NP; j++) begin
                            op_q[j]  <= '0;
                            flg_q[j] <= '0;
                            a_q[j]   <= '0;
                            b_q[j]   <= '0;
                            c_q[j]   <= '0;
                            t_q[j]   <= '0;
                        end
                    end else begin
                        for (int j = 1; j <= NP; j++) begin
                            if (mv[j] && v_in[j]) begin
                                op_q[j]  <= op_in[j];
                                flg_q[j] <= flg_in[j];
                                a_q[j]   <= a_in[j];
                                b_q[j]   <= b_in[j];
                                c_q[j]   <= c_in[j];
                                t_q[j]   <= t_in[j];
                            end
                        end
                    end
                end

                assign m_op   = op_q[NP];
                assign m_flag = flg_q[NP];
                assign m_a    = a_q[NP];
                assign m_b    = b_q[NP];
                assign m_c    = c_q[NP];
                assign m_tag  = t_q[NP];
            end else begin : g_nopre
                assign m_op   = iso_op;
                assign m_flag = iso_flag;
                assign m_a    = iso_a;
                assign m_b    = iso_b;
                assign m_c    = iso_c;
                assign m_tag  = bus.Tag_i;
            end

            if (NUM_POST_REGS > 0) begin : g_post
                localparam int NQ  = NUM_POST_REGS;
                localparam int OFS = NUM_PRE_REGS;
                logic [DSP_WIDTH-1:0] r_q   [1:NQ];
                logic [DSP_WIDTH-1:0] r_in  [1:NQ];
                logic [TAG_WIDTH-1:0] rt_q  [1:NQ];
                logic [TAG_WIDTH-1:0] rt_in [1:NQ];

                // Result payload offered to each post stage.
                always_comb begin
                    r_in[1]  = m_res;
                    rt_in[1] = m_tag;
                    for (int j = 2; j <= NQ; j++) begin
                        r_in[j]  = r_q[j-1];
                        rt_in[j] = rt_q[j-1];
                    end
                end

                // Result registers load only when a valid result moves in.
                always_ff @(posedge clk_i) begin
                    if (!rst_ni) begin
                        for (int j = 1; j <= NQ; j++) begin
                            r_q[j]  <= '0;
                            rt_q[j] <= '0;
                        end
                    end else begin
                        for (int j = 1; j <= NQ; j++) begin
                            if (mv[OFS+j] && v_in[OFS+j]) begin
                                r_q[j]  <= r_in[j];
                                rt_q[j] <= rt_in[j];
                            end
                        end
                    end
                end

                assign bus.Res_o = r_q[NQ];
                assign bus.Tag_o = rt_q[NQ];
            end else begin : g_nopost
                assign bus.Res_o = m_res;
                assign bus.Tag_o = m_tag;
            end
        end
    endgenerate
endmodule
